// File: rtl/mbc_pkg.sv
// mbc_pkg: shared hold-state type, default 100 MHz timing and lowest-set-bit helper
package mbc_pkg;
  typedef enum logic [1:0] {IDLE, HELD, LONG} hold_st_t;
  localparam int DEB_DEF = 16;
  localparam int LONG_DEF = 50_000_000;
  localparam int REPEAT_DEF = 10_000_000;
  function automatic int lsb_idx(input logic [15:0] v);
    lsb_idx = 0;
    for (int i = 15; i >= 0; i--) if (v[i]) lsb_idx = i;
  endfunction
endpackage

// File: rtl/multi_button_ctrl_channel.sv
// btn_channel: synchronise, debounce, edge-detect and hold-time one button
module btn_channel
  import mbc_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_DEF,
  parameter int LONG_CYCLES = LONG_DEF,
  parameter int REPEAT_CYCLES = REPEAT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic button,
  output logic state,
  output logic press,
  output logic release_pulse,
  output logic long_press,
  output logic repeat_pulse
);
  localparam int DW = $clog2(DEB_CYCLES) < 1 ? 1 : $clog2(DEB_CYCLES);
  localparam int HMAX = LONG_CYCLES > REPEAT_CYCLES ? LONG_CYCLES : REPEAT_CYCLES;
  localparam int HW = $clog2(HMAX) < 1 ? 1 : $clog2(HMAX);
  logic [1:0] sync;
  logic synced;
  logic [DW-1:0] cnt;
  logic state_d;
  hold_st_t hs, hs_n;
  logic [HW-1:0] hc, hc_n;
  assign synced = sync[1];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync <= '0;
      cnt <= '0;
      state <= 1'b0;
      state_d <= 1'b0;
      press <= 1'b0;
      release_pulse <= 1'b0;
      hs <= IDLE;
      hc <= '0;
    end else begin
      sync <= {sync[0], button};
      cnt <= (synced == state || cnt == DW'(DEB_CYCLES - 1)) ? '0 : cnt + 1'b1;
      state <= (synced != state && cnt == DW'(DEB_CYCLES - 1)) ? synced : state;
      state_d <= state;
      press <= state & ~state_d;
      release_pulse <= ~state & state_d;
      hs <= hs_n;
      hc <= hc_n;
    end
  always_comb begin
    hs_n = hs;
    hc_n = (&hc) ? hc : hc + 1'b1;
    long_press = 1'b0;
    repeat_pulse = 1'b0;
    if (release_pulse) begin
      hs_n = IDLE;
      hc_n = '0;
    end else
      case (hs)
        IDLE: begin
          hs_n = press ? HELD : IDLE;
          hc_n = '0;
        end
        HELD:
          if (hc == HW'(LONG_CYCLES - 1)) begin
            long_press = 1'b1;
            hs_n = LONG;
            hc_n = '0;
          end
        LONG:
          if (REPEAT_CYCLES == 0) hc_n = hc;
          else if (hc == HW'(REPEAT_CYCLES - 1)) begin
            repeat_pulse = 1'b1;
            hc_n = '0;
          end
        default: begin
          hs_n = IDLE;
          hc_n = '0;
        end
      endcase
  end
endmodule

// File: rtl/multi_button_ctrl.sv
// multi_button_ctrl: N debounced button channels with priority capture of the switch bus
module multi_button_ctrl
  import mbc_pkg::*;
#(
  parameter int N_BTN = 5,
  parameter int DATA_W = 8,
  parameter int DEB_CYCLES = DEB_DEF,
  parameter int LONG_CYCLES = LONG_DEF,
  parameter int REPEAT_CYCLES = REPEAT_DEF,
  parameter int ID_W = N_BTN > 1 ? $clog2(N_BTN) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_BTN-1:0]  button,
  input  logic [DATA_W-1:0] switch,
  output logic [N_BTN-1:0]  state,
  output logic [N_BTN-1:0]  press,
  output logic [N_BTN-1:0]  release_pulse,
  output logic [N_BTN-1:0]  long_press,
  output logic [N_BTN-1:0]  repeat_pulse,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [ID_W-1:0]   btn_id,
  output logic              collision
);
  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_channel #(
      .DEB_CYCLES(DEB_CYCLES),
      .LONG_CYCLES(LONG_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_ch (
      .clk(clk),
      .rst(rst),
      .button(button[i]),
      .state(state[i]),
      .press(press[i]),
      .release_pulse(release_pulse[i]),
      .long_press(long_press[i]),
      .repeat_pulse(repeat_pulse[i])
    );
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      valid <= 1'b0;
      data <= '0;
      btn_id <= '0;
      collision <= 1'b0;
    end else begin
      valid <= |press;
      collision <= (press & (press - 1'b1)) != '0;
      if (|press) begin
        data <= switch;
        btn_id <= ID_W'(lsb_idx(16'(press)));
      end
    end
endmodule

// File: tb/tb_multi_button_ctrl.sv
// tb_multi_button_ctrl: directed and random checks of multi_button_ctrl against a behavioural model
module tb_multi_button_ctrl;
  localparam int DEB = 4;
  localparam int LNG = 20;
  localparam int REP = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] button = '0;
  logic [7:0] switch = '0;
  logic [3:0] state, press, release_pulse, long_press, repeat_pulse;
  logic valid, collision;
  logic [7:0] data;
  logic [1:0] btn_id;
  int checks = 0;
  int errors = 0;
  logic [3:0] samp[$];
  logic [3:0] m_state, m_state_d, m_press, m_rel, m_long, m_rep;
  logic m_valid, m_coll;
  logic [7:0] m_data;
  logic [1:0] m_id;
  int held[4];
  int ecount;
  logic ok, seen;
  int t_long, r1, r2, extra;
  always #5 clk = ~clk;
  multi_button_ctrl #(
    .N_BTN(4),
    .DATA_W(8),
    .DEB_CYCLES(DEB),
    .LONG_CYCLES(LNG),
    .REPEAT_CYCLES(REP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .button(button),
    .switch(switch),
    .state(state),
    .press(press),
    .release_pulse(release_pulse),
    .long_press(long_press),
    .repeat_pulse(repeat_pulse),
    .valid(valid),
    .data(data),
    .btn_id(btn_id),
    .collision(collision)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic int lowest(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction
  task automatic model_reset();
    samp = '{4'h0, 4'h0};
    {m_state, m_state_d, m_press, m_rel, m_long, m_rep} = '0;
    {m_valid, m_coll, m_data, m_id} = '0;
    for (int c = 0; c < 4; c++) held[c] = -1;
    ecount = 0;
  endtask
  task automatic model_step();
    logic [3:0] nxt;
    int n, d;
    bit all_diff;
    if (rst) begin
      model_reset();
      return;
    end
    m_valid = |m_press;
    m_coll = $countones(m_press) > 1;
    if (|m_press) begin
      m_data = switch;
      m_id = 2'(lowest(m_press));
    end
    samp.push_back(button);
    n = samp.size();
    nxt = m_state;
    for (int c = 0; c < 4; c++)
      if (n >= DEB + 2) begin
        all_diff = 1;
        for (int j = 0; j < DEB; j++) if (samp[n-3-j][c] == m_state[c]) all_diff = 0;
        if (all_diff) nxt[c] = ~m_state[c];
      end
    m_press = m_state & ~m_state_d;
    m_rel = ~m_state & m_state_d;
    m_state_d = m_state;
    m_state = nxt;
    ecount++;
    for (int c = 0; c < 4; c++) begin
      m_long[c] = 1'b0;
      m_rep[c] = 1'b0;
      if (m_rel[c]) held[c] = -1;
      else if (held[c] >= 0) begin
        d = ecount - held[c];
        m_long[c] = d == LNG;
        m_rep[c] = REP != 0 && d > LNG && (d - LNG) % REP == 0;
      end
      if (m_press[c]) held[c] = ecount;
    end
  endtask
  task automatic compare_all();
    chk("state", 32'(state), 32'(m_state));
    chk("press", 32'(press), 32'(m_press));
    chk("release", 32'(release_pulse), 32'(m_rel));
    chk("long_press", 32'(long_press), 32'(m_long));
    chk("repeat_pulse", 32'(repeat_pulse), 32'(m_rep));
    chk("valid", 32'(valid), 32'(m_valid));
    chk("collision", 32'(collision), 32'(m_coll));
    chk("data", 32'(data), 32'(m_data));
    chk("btn_id", 32'(btn_id), 32'(m_id));
  endtask
  task automatic check_zero(input string tag);
    chk({tag, "_state"}, 32'(state), 32'h0);
    chk({tag, "_press"}, 32'(press), 32'h0);
    chk({tag, "_release"}, 32'(release_pulse), 32'h0);
    chk({tag, "_long"}, 32'(long_press), 32'h0);
    chk({tag, "_repeat"}, 32'(repeat_pulse), 32'h0);
    chk({tag, "_valid"}, 32'(valid), 32'h0);
    chk({tag, "_collision"}, 32'(collision), 32'h0);
    chk({tag, "_data"}, 32'(data), 32'h0);
    chk({tag, "_btn_id"}, 32'(btn_id), 32'h0);
  endtask
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask
  initial begin
    #200000;
    $display("FAIL timeout checks %0d errors %0d", checks, errors);
    $fatal(1, "timeout");
  end
  initial begin
    model_reset();
    button = 4'b0001;
    #1;
    check_zero("reset");
    tick();
    tick();
    rst = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 6) chk("rst_press_early", 32'(press[0]), 32'h0);
      if (i == 7) chk("rst_press_at7", 32'(press[0]), 32'h1);
      if (i == 8) begin
        chk("rst_valid", 32'(valid), 32'h1);
        chk("rst_btn_id", 32'(btn_id), 32'h0);
      end
    end
    button = 4'b0000;
    repeat (12) tick();
    switch = 8'hA5;
    button[2] = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      ok = press[2];
    end
    chk("a5_press_seen", 32'(ok), 32'h1);
    tick();
    chk("a5_valid", 32'(valid), 32'h1);
    chk("a5_data", 32'(data), 32'hA5);
    chk("a5_btn_id", 32'(btn_id), 32'h2);
    switch = 8'h00;
    tick();
    chk("a5_valid_low", 32'(valid), 32'h0);
    chk("a5_data_hold", 32'(data), 32'hA5);
    button[2] = 1'b0;
    repeat (12) tick();
    button[1] = 1'b1;
    repeat (3) tick();
    button[1] = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      tick();
      seen |= press[1];
    end
    chk("glitch_no_press", 32'(seen), 32'h0);
    chk("glitch_state", 32'(state[1]), 32'h0);
    button[1] = 1'b1;
    repeat (4) tick();
    button[1] = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      tick();
      seen |= press[1];
    end
    chk("stable4_press", 32'(seen), 32'h1);
    repeat (8) tick();
    button[3] = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      ok = press[3];
    end
    chk("hold_press_seen", 32'(ok), 32'h1);
    t_long = -1;
    r1 = -1;
    r2 = -1;
    for (int i = 1; i <= 50; i++) begin
      tick();
      if (long_press[3] && t_long < 0) t_long = i;
      if (repeat_pulse[3]) begin
        if (r1 < 0) r1 = i;
        else if (r2 < 0) r2 = i;
      end
    end
    chk("long_at_20", 32'(t_long), 32'd20);
    chk("repeat1_at_28", 32'(r1), 32'd28);
    chk("repeat2_at_36", 32'(r2), 32'd36);
    button[3] = 1'b0;
    ok = 1'b0;
    extra = 0;
    repeat (20) begin
      tick();
      if (release_pulse[3]) ok = 1'b1;
      if (ok && (long_press[3] || repeat_pulse[3])) extra++;
    end
    chk("hold_release_seen", 32'(ok), 32'h1);
    chk("no_pulse_after_release", 32'(extra), 32'h0);
    switch = 8'h3C;
    button = 4'b1001;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      ok = |press;
    end
    chk("coll_press_vec", 32'(press), 32'h9);
    tick();
    chk("coll_valid", 32'(valid), 32'h1);
    chk("coll_btn_id", 32'(btn_id), 32'h0);
    chk("coll_data", 32'(data), 32'h3C);
    chk("coll_flag", 32'(collision), 32'h1);
    button = 4'b0000;
    repeat (12) tick();
    button[2] = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      ok = press[2];
    end
    chk("midhold_press_seen", 32'(ok), 32'h1);
    repeat (10) tick();
    rst = 1'b1;
    #1;
    check_zero("midhold_rst");
    model_reset();
    tick();
    tick();
    rst = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      ok = press[2];
    end
    chk("repress_seen", 32'(ok), 32'h1);
    t_long = -1;
    for (int i = 1; i <= 25; i++) begin
      tick();
      if (long_press[2] && t_long < 0) t_long = i;
    end
    chk("repress_long_at_20", 32'(t_long), 32'd20);
    button[2] = 1'b0;
    repeat (12) tick();
    repeat (400) begin
      if ($urandom_range(0, 11) == 0) button[$urandom_range(0, 3)] ^= 1'b1;
      switch = 8'($urandom);
      tick();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
